// File: rtl/tsxb_ports_v2.sv
// TSXB Z80 I/O port decoder: covox/SounDrive DAC staging with tick commit,
// plus a bank of R/W config registers behind the TSXB config port.
module tsxb_ports_v2 #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned N_REGS     = 8,
    parameter logic [7:0]  BASE_PORT  = 8'hAF,
    parameter logic [7:0]  COVOX_PORT = 8'hFB,
    parameter logic [7:0]  ID_VAL     = 8'hB2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    input  logic                  rnw,
    output logic                  port_en,
    input  logic                  port_req,
    output logic                  port_stb,
    output logic                  covox_stb,
    output logic [N_CH-1:0]       sdrv_stb,
    input  logic                  dac_tick,
    output logic [8*N_CH-1:0]     dac_out,
    output logic                  dac_upd,
    output logic [8*N_REGS-1:0]   cfg_out
);

    localparam logic [7:0] IDX_STATUS = 8'h03;

    // SounDrive port for each channel
    function automatic logic [7:0] sd_port(input int unsigned ch);
        case (ch)
            0:       sd_port = 8'h0F;
            1:       sd_port = 8'h1F;
            2:       sd_port = 8'h4F;
            default: sd_port = 8'h5F;
        endcase
    endfunction

    // Config register index hit test for a register-index byte
    function automatic logic cfg_hit(input logic [7:0] idx);
        cfg_hit = idx[7] && ({1'b0, idx[6:0]} < 8'(N_REGS));
    endfunction

    logic                   r_req_d;
    logic                   r_port_stb;
    logic                   r_covox_stb;
    logic [N_CH-1:0]        r_sdrv_stb;
    logic [15:0]            r_cap_addr;
    logic [7:0]             r_cap_data;
    logic                   r_cap_rnw;
    logic [N_CH-1:0][7:0]   r_stg;
    logic [N_CH-1:0][7:0]   r_dac;
    logic [N_CH-1:0]        r_pend;
    logic                   r_ovr;
    logic                   r_dac_upd;
    logic [N_REGS-1:0][7:0] r_cfg;

    logic                   w_first;
    logic                   w_covox_en;
    logic                   w_tsxb_en;
    logic [N_CH-1:0]        w_sdrv_en;
    logic [N_CH-1:0]        w_cap_sdrv;
    logic                   w_wr;
    logic [N_CH-1:0]        w_ch_wr;
    logic [N_CH-1:0][7:0]   w_stg_nxt;
    logic                   w_ovr_set;
    logic                   w_ovr_clr;
    logic [3:0]             w_pend4;
    logic [7:0]             w_idx;
    logic [7:0]             w_cap_idx;

    assign w_first    = port_req & ~r_req_d;
    assign w_idx      = addr[15:8];
    assign w_cap_idx  = r_cap_addr[15:8];
    assign w_covox_en = (addr[7:0] == COVOX_PORT);
    assign w_tsxb_en  = (addr[7:0] == BASE_PORT);
    assign w_wr       = r_port_stb & ~r_cap_rnw;

    // Live and captured SounDrive decode, channel write enables, next staging
    always_comb begin
        w_sdrv_en  = '0;
        w_cap_sdrv = '0;
        w_ch_wr    = '0;
        w_stg_nxt  = r_stg;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_sdrv_en[i]  = (addr[7:0] == sd_port(i));
            w_cap_sdrv[i] = (r_cap_addr[7:0] == sd_port(i));
            w_ch_wr[i]    = w_wr & (w_cap_sdrv[i] | (r_cap_addr[7:0] == COVOX_PORT));
            if (w_ch_wr[i]) begin
                w_stg_nxt[i] = r_cap_data;
            end
        end
    end

    // Overrun set/clear terms; set takes priority in the register update
    assign w_ovr_set = ~dac_tick & (|(w_ch_wr & r_pend));
    assign w_ovr_clr = w_wr & (r_cap_addr[7:0] == BASE_PORT) &
                       (w_cap_idx == IDX_STATUS) & r_cap_data[7];

    // Pending mask padded to the 4-bit STATUS field
    always_comb begin
        w_pend4 = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_pend4[i] = r_pend[i];
        end
    end

    // Read mux and port claim on the live address
    always_comb begin
        data_out = 8'hFF;
        case (w_idx)
            8'h00:   data_out = ID_VAL;
            8'h01:   data_out = 8'hAA;
            8'h02:   data_out = 8'h55;
            8'h03:   data_out = {r_ovr, 3'b000, w_pend4};
            default: begin
                for (int unsigned k = 0; k < N_REGS; k++) begin
                    if (cfg_hit(w_idx) && (w_idx[5:0] == 6'(k))) begin
                        data_out = r_cfg[k];
                    end
                end
            end
        endcase
        if (rnw) begin
            port_en = w_tsxb_en & ((w_idx <= IDX_STATUS) | cfg_hit(w_idx));
        end else begin
            port_en = w_covox_en | (|w_sdrv_en) | w_tsxb_en;
        end
    end

    // Request edge detect, capture and strobe generation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_d     <= 1'b0;
            r_port_stb  <= 1'b0;
            r_covox_stb <= 1'b0;
            r_sdrv_stb  <= '0;
            r_cap_addr  <= '0;
            r_cap_data  <= '0;
            r_cap_rnw   <= 1'b1;
        end else begin
            r_req_d     <= port_req;
            r_port_stb  <= w_first;
            r_covox_stb <= w_first & ~rnw & w_covox_en;
            r_sdrv_stb  <= (w_first & ~rnw) ? w_sdrv_en : '0;
            if (w_first) begin
                r_cap_addr <= addr;
                r_cap_data <= data_in;
                r_cap_rnw  <= rnw;
            end
        end
    end

    // DAC staging, pending mask, overrun and tick commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stg     <= {N_CH{8'h80}};
            r_dac     <= {N_CH{8'h80}};
            r_pend    <= '0;
            r_ovr     <= 1'b0;
            r_dac_upd <= 1'b0;
        end else begin
            r_stg     <= w_stg_nxt;
            r_dac_upd <= dac_tick;
            r_ovr     <= w_ovr_set | (r_ovr & ~w_ovr_clr);
            if (dac_tick) begin
                r_dac  <= w_stg_nxt;
                r_pend <= '0;
            end else begin
                r_pend <= r_pend | w_ch_wr;
            end
        end
    end

    // Config register writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else begin
            for (int unsigned k = 0; k < N_REGS; k++) begin
                if (w_wr && (r_cap_addr[7:0] == BASE_PORT) && cfg_hit(w_cap_idx) &&
                    (w_cap_idx[5:0] == 6'(k))) begin
                    r_cfg[k] <= r_cap_data;
                end
            end
        end
    end

    assign port_stb  = r_port_stb;
    assign covox_stb = r_covox_stb;
    assign sdrv_stb  = r_sdrv_stb;
    assign dac_out   = r_dac;
    assign dac_upd   = r_dac_upd;
    assign cfg_out   = r_cfg;

endmodule

// File: tb/tb_tsxb_ports_v2.sv
// Directed bench for tsxb_ports_v2 (N_CH=4 main instance, N_CH=2 side instance).
module tb_tsxb_ports_v2;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        rnw;
    logic        port_req;
    logic        dac_tick;

    logic [7:0]  data_out;
    logic        port_en;
    logic        port_stb;
    logic        covox_stb;
    logic [3:0]  sdrv_stb;
    logic [31:0] dac_out;
    logic        dac_upd;
    logic [63:0] cfg_out;

    logic [7:0]  data_out2;
    logic        port_en2;
    logic        port_stb2;
    logic        covox_stb2;
    logic [1:0]  sdrv_stb2;
    logic [15:0] dac_out2;
    logic        dac_upd2;
    logic [63:0] cfg_out2;

    int n_vec  = 0;
    int n_fail = 0;
    int stb_cnt;

    tsxb_ports_v2 #(.N_CH(4), .N_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .data_out(data_out), .rnw(rnw), .port_en(port_en),
        .port_req(port_req), .port_stb(port_stb), .covox_stb(covox_stb),
        .sdrv_stb(sdrv_stb), .dac_tick(dac_tick), .dac_out(dac_out),
        .dac_upd(dac_upd), .cfg_out(cfg_out)
    );

    tsxb_ports_v2 #(.N_CH(2), .N_REGS(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .data_out(data_out2), .rnw(rnw), .port_en(port_en2),
        .port_req(port_req), .port_stb(port_stb2), .covox_stb(covox_stb2),
        .sdrv_stb(sdrv_stb2), .dac_tick(dac_tick), .dac_out(dac_out2),
        .dac_upd(dac_upd2), .cfg_out(cfg_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set up a live read address (combinational outputs settle after #1)
    task automatic rd(input logic [15:0] a);
        port_req = 1'b0;
        rnw      = 1'b1;
        addr     = a;
        #1;
    endtask

    // One-cycle write request; leaves the bench in the strobe cycle
    task automatic wr_start(input logic [15:0] a, input logic [7:0] d);
        addr     = a;
        data_in  = d;
        rnw      = 1'b0;
        port_req = 1'b1;
        step();
        port_req = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        addr     = 16'h0000;
        data_in  = 8'h00;
        rnw      = 1'b1;
        port_req = 1'b0;
        dac_tick = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_port_stb", 64'(port_stb), 64'h0);
        chk("rst_dac_out",  64'(dac_out), 64'h80808080);
        chk("rst_dac_upd",  64'(dac_upd), 64'h0);
        chk("rst_cfg_out",  cfg_out, 64'h0);
        rst_n = 1'b1;
        step();

        // Fixed read map
        rd(16'h00AF); chk("rd_id",     64'(data_out), 64'hB2); chk("en_id", 64'(port_en), 64'h1);
        rd(16'h01AF); chk("rd_aa",     64'(data_out), 64'hAA);
        rd(16'h02AF); chk("rd_55",     64'(data_out), 64'h55);
        rd(16'h03AF); chk("rd_status", 64'(data_out), 64'h00); chk("en_status", 64'(port_en), 64'h1);
        rd(16'h04AF); chk("rd_unimpl", 64'(data_out), 64'hFF); chk("en_unimpl", 64'(port_en), 64'h0);

        // Held request: exactly one strobe, one clock after rise
        addr = 16'h81AF; data_in = 8'h3C; rnw = 1'b0; port_req = 1'b1;
        stb_cnt = 0;
        step();
        chk("held_stb_first", 64'(port_stb), 64'h1);
        if (port_stb) stb_cnt++;
        for (int c = 0; c < 4; c++) begin
            step();
            if (port_stb) stb_cnt++;
        end
        chk("held_stb_count", 64'(stb_cnt), 64'd1);
        port_req = 1'b0;
        step();
        chk("cfg1_out", cfg_out, 64'h0000_0000_0000_3C00);
        rd(16'h81AF); chk("cfg1_read", 64'(data_out), 64'h3C); chk("cfg1_en", 64'(port_en), 64'h1);

        // SounDrive ch1 write then tick
        wr_start(16'h001F, 8'h10);
        chk("sd1_stb", 64'(sdrv_stb), 64'h2);
        chk("sd1_covox_stb", 64'(covox_stb), 64'h0);
        step();
        rd(16'h03AF); chk("sd1_pending", 64'(data_out), 64'h02);
        dac_tick = 1'b1;
        step();
        dac_tick = 1'b0;
        chk("sd1_upd", 64'(dac_upd), 64'h1);
        chk("sd1_dac", 64'(dac_out), 64'h80801080);
        rd(16'h03AF); chk("sd1_pend_clr", 64'(data_out), 64'h00);
        step();
        chk("sd1_upd_once", 64'(dac_upd), 64'h0);

        // Covox then ch0 with no tick -> overrun
        wr_start(16'h00FB, 8'h40);
        chk("cov_stb", 64'(covox_stb), 64'h1);
        chk("cov_sdrv_stb", 64'(sdrv_stb), 64'h0);
        step();
        wr_start(16'h000F, 8'h20);
        step();
        rd(16'h03AF); chk("ovr_status", 64'(data_out), 64'h8F);
        chk("ovr_dac_hold", 64'(dac_out), 64'h80801080);
        wr_start(16'h03AF, 8'h80);
        step();
        rd(16'h03AF); chk("ovr_clear", 64'(data_out), 64'h0F);

        // Commit everything, then ch2 pending + coincident write/tick
        dac_tick = 1'b1;
        step();
        dac_tick = 1'b0;
        chk("cov_dac", 64'(dac_out), 64'h40404020);
        wr_start(16'h004F, 8'h66);
        step();
        rd(16'h03AF); chk("ch2_pending", 64'(data_out), 64'h04);
        wr_start(16'h004F, 8'h77);
        dac_tick = 1'b1;
        step();
        dac_tick = 1'b0;
        chk("coin_upd", 64'(dac_upd), 64'h1);
        chk("coin_dac", 64'(dac_out), 64'h40774020);
        rd(16'h03AF); chk("coin_status", 64'(data_out), 64'h00);

        // N_CH=2 instance: ch2 port is not decoded
        chk("n2_dac_before", 64'(dac_out2), 64'h4020);
        addr = 16'h004F; rnw = 1'b0; #1;
        chk("n2_port_en", 64'(port_en2), 64'h0);
        chk("n4_port_en", 64'(port_en), 64'h1);
        wr_start(16'h004F, 8'h99);
        chk("n2_sdrv_stb", 64'(sdrv_stb2), 64'h0);
        step();
        dac_tick = 1'b1;
        step();
        dac_tick = 1'b0;
        chk("n2_dac_after", 64'(dac_out2), 64'h4020);
        chk("n4_dac_after", 64'(dac_out), 64'h40994020);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
